fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter: RESET_PC, default 32'h0000_0000, first instruction address after reset.
REQ-002 SHALL provide ports:
- clk  in  1  rising-edge clock.
- nrst  in  1  reset; synchronous, active-low.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  memory returns imem_rdata this cycle for the outstanding request.
- imem_rdata  in  32  fetched instruction.
- stall  in  1  decode cannot accept; holds IF/ID.
- redirect  in  1  one-cycle pulse; taken branch or jump resolved downstream.
- redirect_target  in  32  new PC; bits [1:0] ignored.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_instr  out  32  instruction to decode.
- if_id_pc4  out  32  address of instruction + 4.
- opcode  out  6  if_id_instr[31:26]; feeds the control decoder.

Function
REQ-003 SHALL implement FSM states BOOT, FETCH, HOLD; BOOT lasts exactly one cycle after reset release, then FETCH.
REQ-004 SHALL drive imem_req=1 only in FETCH; imem_addr = pc, stable while imem_req=1 and imem_ready=0.
REQ-005 SHALL define slot_free = !if_id_valid || !stall.
REQ-006 In FETCH with imem_ready=1, no redirect, slot_free=1: SHALL load IF/ID (instr, pc+4, valid=1), pc <= pc+4, remain FETCH; response visible on if_id_* the following cycle.
REQ-007 In FETCH with imem_ready=1, no redirect, slot_free=0: SHALL store the response in the skid buffer, pc <= pc+4, go to HOLD.
REQ-008 In HOLD: SHALL keep imem_req=0; when stall=0, SHALL move skid into IF/ID (valid=1) and return to FETCH.
REQ-009 When if_id_valid=1, stall=0 and no new load occurs that cycle, SHALL clear if_id_valid (instruction consumed).
REQ-010 While stall=1 and no redirect, SHALL hold if_id_instr/if_id_pc4/if_id_valid unchanged.
REQ-011 On redirect: SHALL clear if_id_valid and the skid buffer next cycle, pc <= {redirect_target[31:2],2'b00}; redirect overrides stall.
REQ-012 Redirect in FETCH with imem_ready=0 (request outstanding): SHALL set kill flag, keep imem_addr at the old pc until imem_ready, discard that response, then issue the target fetch.
REQ-013 Redirect in the same cycle as imem_ready=1: SHALL discard the response; next request uses the target.
REQ-014 Redirect in HOLD or BOOT: SHALL discard skid, go to FETCH with pc = target.
REQ-015 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-016 opcode SHALL be combinational from if_id_instr and SHALL equal 6'b000000 whenever if_id_valid=0 (if_id_instr forced to NOP 32'h0 on flush).

Reset
REQ-017 With nrst=0 at a clock edge: pc=RESET_PC, state=BOOT, kill=0, skid empty, imem_req=0, if_id_valid=0, if_id_instr=32'h0, if_id_pc4=32'h0, opcode=6'b0.
REQ-018 Reset mid-fetch SHALL abandon the outstanding request; any imem_ready during reset is ignored.

Structure
REQ-019 Shared package mips_pkg SHALL hold: RESET_PC default, state encoding (BOOT/FETCH/HOLD), NOP_INSTR, opcode field bounds [31:26].
REQ-020 Skid buffer SHALL be a sub-module fetch_skid_buf (32-bit instr + 32-bit pc4 + valid, load/clear/pop).

Verification
REQ-021 Reset release, imem_ready tied 1 -> addrs 0,4,8 on consecutive cycles; if_id_pc4 = 4,8,12; first if_id_valid two cycles after BOOT.
REQ-022 stall=1 for 3 cycles while IF/ID valid and memory returns 32'h8C22_0004 -> FSM enters HOLD, imem_req=0, IF/ID unchanged; on stall=0 if_id_instr=32'h8C22_0004, opcode=6'b100011.
REQ-023 Redirect to 32'h0000_0103 while imem_ready=0 for 2 more cycles -> stale response dropped, next request addr 32'h0000_0100, if_id_valid=0 in between.
REQ-024 Redirect and imem_ready=1 same cycle with stall=1 -> IF/ID flushed (valid=0, opcode=0), next addr = target.
REQ-025 pc=32'hFFFF_FFFC, ready=1 -> if_id_pc4=32'h0, next imem_addr=32'h0.
REQ-026 nrst=0 asserted during outstanding request -> all outputs at REQ-017 values next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch slice.
//   RESET_PC_DEFAULT : first fetch address after reset
//   fetch_state_e    : fetch FSM encoding (BOOT/FETCH/HOLD)
//   NOP_INSTR        : instruction written into IF/ID on flush/reset
//   OPCODE_MSB/LSB   : opcode field bounds within an instruction word
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam int unsigned OPCODE_MSB       = 31;
   localparam int unsigned OPCODE_LSB       = 26;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction that could not enter
// IF/ID because decode was stalled.
//   clk, nrst          : clock, synchronous active-low reset
//   load               : capture in_instr/in_pc4, mark valid
//   clear              : drop contents (flush); wins over load/pop
//   pop                : contents consumed, mark empty
//   in_instr, in_pc4   : incoming instruction and its pc+4
//   instr, pc4, valid  : stored entry
module fetch_skid_buf
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        load,
   input  logic        clear,
   input  logic        pop,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc4,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (!nrst || clear) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc4   <= '0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= in_instr;
         pc4   <= in_pc4;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word fetches, fills the IF/ID register,
// parks a response in a skid buffer while decode stalls, and handles
// redirects (including one that arrives with a request still outstanding).
//   clk, nrst                 : clock, synchronous active-low reset
//   imem_req, imem_addr       : instruction-memory read request / address
//   imem_ready, imem_rdata    : memory response for the outstanding request
//   stall                     : decode cannot accept
//   redirect, redirect_target : taken branch/jump pulse and new PC
//   if_id_valid/instr/pc4     : IF/ID register
//   opcode                    : if_id_instr[31:26]
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        nrst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic [5:0]  opcode
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  tgt_q, tgt_d;
   logic         kill_q, kill_d;
   logic         valid_d;
   logic [31:0]  instr_d, pc4_d;
   logic         skid_load, skid_clear, skid_pop;
   logic [31:0]  skid_instr, skid_pc4;
   logic         skid_valid;
   logic [31:0]  pc_plus4;
   logic         slot_free;

   assign pc_plus4  = pc_q + 32'd4;
   assign slot_free = !if_id_valid || !stall;
   assign imem_req  = (state_q == FETCH);
   assign imem_addr = pc_q;
   assign opcode    = if_id_instr[OPCODE_MSB:OPCODE_LSB];

   fetch_skid_buf u_skid (
      .clk      (clk),
      .nrst     (nrst),
      .load     (skid_load),
      .clear    (skid_clear),
      .pop      (skid_pop),
      .in_instr (imem_rdata),
      .in_pc4   (pc_plus4),
      .instr    (skid_instr),
      .pc4      (skid_pc4),
      .valid    (skid_valid)
   );

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         tgt_q       <= RESET_PC;
         kill_q      <= 1'b0;
         if_id_valid <= 1'b0;
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         tgt_q       <= tgt_d;
         kill_q      <= kill_d;
         if_id_valid <= valid_d;
         if_id_instr <= instr_d;
         if_id_pc4   <= pc4_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      tgt_d      = tgt_q;
      kill_d     = kill_q;
      valid_d    = if_id_valid;
      instr_d    = if_id_instr;
      pc4_d      = if_id_pc4;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      skid_pop   = 1'b0;

      // Consumed by decode; any load below overrides this.
      if (if_id_valid && !stall) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         pc4_d   = '0;
      end

      if (redirect) begin
         valid_d    = 1'b0;
         instr_d    = NOP_INSTR;
         pc4_d      = '0;
         skid_clear = 1'b1;
         if (state_q == FETCH && !imem_ready) begin
            // Request in flight: address must stay put until the memory
            // answers, so park the target and drop that answer later.
            kill_d = 1'b1;
            tgt_d  = word_align(redirect_target);
         end else begin
            state_d = FETCH;
            pc_d    = word_align(redirect_target);
            kill_d  = 1'b0;
         end
      end else begin
         unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
               if (imem_ready) begin
                  if (kill_q) begin
                     kill_d = 1'b0;
                     pc_d   = tgt_q;
                  end else if (slot_free) begin
                     valid_d = 1'b1;
                     instr_d = imem_rdata;
                     pc4_d   = pc_plus4;
                     pc_d    = pc_plus4;
                  end else begin
                     skid_load = 1'b1;
                     pc_d      = pc_plus4;
                     state_d   = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  if (skid_valid) begin
                     valid_d = 1'b1;
                     instr_d = skid_instr;
                     pc4_d   = skid_pc4;
                  end
                  skid_pop = 1'b1;
                  state_d  = FETCH;
               end
            end
            default: state_d = BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        nrst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic [5:0]  opcode;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_t;

   logic [31:0] exp_addr_q[$];
   ifid_t       exp_ifid_q[$];
   int          total  = 0;
   int          passed = 0;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .nrst            (nrst),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .if_id_valid     (if_id_valid),
      .if_id_instr     (if_id_instr),
      .if_id_pc4       (if_id_pc4),
      .opcode          (opcode)
   );

   always #5 clk = ~clk;

   // Memory contents: address-derived pattern, with one load word at 0x10.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h8C22_0004;
      return {a[15:0] ^ 16'hA5C3, a[15:0]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_addr(input logic [31:0] a);
      exp_addr_q.push_back(a);
   endtask

   task automatic push_ifid(input logic [31:0] instr, input logic [31:0] pc4);
      ifid_t e;
      e.instr = instr;
      e.pc4   = pc4;
      exp_ifid_q.push_back(e);
   endtask

   // Monitor: mid-cycle, compare every accepted fetch and every instruction
   // handed to decode against the scoreboard queues.
   initial begin
      ifid_t       e;
      logic [31:0] ea;
      forever begin
         @(negedge clk);
         if (nrst === 1'b1) begin
            if (imem_req && imem_ready) begin
               if (exp_addr_q.size() == 0) begin
                  total++;
                  $display("FAIL fetch_addr: unexpected fetch of %h, none expected", imem_addr);
               end else begin
                  ea = exp_addr_q.pop_front();
                  check("fetch_addr", imem_addr, ea);
               end
            end
            if (if_id_valid && !stall && !redirect) begin
               if (exp_ifid_q.size() == 0) begin
                  total++;
                  $display("FAIL ifid_issue: unexpected instr %h pc4 %h, none expected", if_id_instr, if_id_pc4);
               end else begin
                  e = exp_ifid_q.pop_front();
                  check("ifid_instr", if_id_instr, e.instr);
                  check("ifid_pc4", if_id_pc4, e.pc4);
                  check("ifid_opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      nrst = 1'b0; stall = 1'b0; redirect = 1'b0;
      redirect_target = '0; imem_ready = 1'b1;

      // Reset and straight-line fetch with memory always ready.
      push_addr(32'h0); push_addr(32'h4); push_addr(32'h8);
      push_ifid(mem_word(32'h0), 32'h4);
      push_ifid(mem_word(32'h4), 32'h8);
      push_ifid(mem_word(32'h8), 32'hC);
      repeat (3) step();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, if_id_valid}, 32'd0);
      check("rst_instr", if_id_instr, 32'h0);
      check("rst_pc4", if_id_pc4, 32'h0);
      check("rst_opcode", {26'd0, opcode}, 32'd0);
      nrst = 1'b1;
      step();
      check("boot_req", {31'd0, imem_req}, 32'd1);
      check("boot_addr", imem_addr, 32'h0);
      check("boot_valid", {31'd0, if_id_valid}, 32'd0);
      step();
      check("seq_valid", {31'd0, if_id_valid}, 32'd1);
      check("seq_pc4_a", if_id_pc4, 32'h4);
      check("seq_addr_a", imem_addr, 32'h4);
      step();
      check("seq_pc4_b", if_id_pc4, 32'h8);
      step();
      check("seq_pc4_c", if_id_pc4, 32'hC);
      imem_ready = 1'b0;
      step();
      check("seq_drain_valid", {31'd0, if_id_valid}, 32'd0);
      check("seq_idle_addr", imem_addr, 32'hC);

      // Stall for three cycles while a response arrives: skid + HOLD.
      push_addr(32'hC); push_addr(32'h10);
      push_ifid(mem_word(32'hC), 32'h10);
      push_ifid(32'h8C22_0004, 32'h14);
      imem_ready = 1'b1;
      step();
      check("hold_pre_pc4", if_id_pc4, 32'h10);
      stall = 1'b1;
      step();
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_instr_1", if_id_instr, mem_word(32'hC));
      imem_ready = 1'b0;
      step();
      check("hold_req_2", {31'd0, imem_req}, 32'd0);
      check("hold_valid_2", {31'd0, if_id_valid}, 32'd1);
      step();
      check("hold_instr_3", if_id_instr, mem_word(32'hC));
      check("hold_pc4_3", if_id_pc4, 32'h10);
      stall = 1'b0;
      step();
      check("unhold_instr", if_id_instr, 32'h8C22_0004);
      check("unhold_opcode", {26'd0, opcode}, 32'h23);
      check("unhold_pc4", if_id_pc4, 32'h14);
      check("unhold_addr", imem_addr, 32'h14);
      step();
      check("unhold_drain", {31'd0, if_id_valid}, 32'd0);

      // Redirect with a request outstanding: stale answer dropped.
      push_addr(32'h14);
      redirect = 1'b1; redirect_target = 32'h0000_0103;
      step();
      redirect = 1'b0;
      check("kill_addr_0", imem_addr, 32'h14);
      check("kill_valid_0", {31'd0, if_id_valid}, 32'd0);
      step();
      check("kill_addr_1", imem_addr, 32'h14);
      step();
      check("kill_addr_2", imem_addr, 32'h14);
      imem_ready = 1'b1;
      step();
      check("kill_new_addr", imem_addr, 32'h100);
      check("kill_dropped", {31'd0, if_id_valid}, 32'd0);

      // Redirect + ready + stall in the same cycle flushes IF/ID.
      push_addr(32'h100); push_addr(32'h104);
      step();
      check("flush_pre_pc4", if_id_pc4, 32'h104);
      check("flush_pre_opcode", {26'd0, opcode}, {26'd0, 6'b101001});
      stall = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0200;
      step();
      redirect = 1'b0;
      check("flush_valid", {31'd0, if_id_valid}, 32'd0);
      check("flush_opcode", {26'd0, opcode}, 32'd0);
      check("flush_instr", if_id_instr, 32'h0);
      check("flush_addr", imem_addr, 32'h200);

      // PC wrap at the top of the address space.
      push_addr(32'h200); push_addr(32'hFFFF_FFFC); push_addr(32'h0);
      push_ifid(mem_word(32'hFFFF_FFFC), 32'h0);
      push_ifid(mem_word(32'h0), 32'h4);
      stall = 1'b0; redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      check("wrap_pc4", if_id_pc4, 32'h0);
      check("wrap_valid", {31'd0, if_id_valid}, 32'd1);
      check("wrap_next_addr", imem_addr, 32'h0);
      step();
      check("wrap_pc4_b", if_id_pc4, 32'h4);
      check("wrap_addr_b", imem_addr, 32'h4);
      imem_ready = 1'b0;
      step();
      check("wrap_drain", {31'd0, if_id_valid}, 32'd0);

      // Reset during an outstanding request; memory answer ignored.
      nrst = 1'b0; imem_ready = 1'b1;
      step();
      check("mrst_req", {31'd0, imem_req}, 32'd0);
      check("mrst_valid", {31'd0, if_id_valid}, 32'd0);
      check("mrst_instr", if_id_instr, 32'h0);
      check("mrst_pc4", if_id_pc4, 32'h0);
      check("mrst_opcode", {26'd0, opcode}, 32'd0);
      step();
      push_addr(32'h0);
      push_ifid(mem_word(32'h0), 32'h4);
      nrst = 1'b1;
      step();
      check("mrst_boot_req", {31'd0, imem_req}, 32'd1);
      check("mrst_boot_addr", imem_addr, 32'h0);
      step();
      check("mrst_pc4", if_id_pc4, 32'h4);
      imem_ready = 1'b0;
      step();
      step();
      check("addr_q_empty", exp_addr_q.size(), 32'd0);
      check("ifid_q_empty", exp_ifid_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
